// File: rtl/drawing_fractal_if.sv
// Command and frame-store bus of the fractal drawing engine.
// The engine connects through the slave modport; the commander and frame store use the master modport.
interface drawing_fractal_if;
  logic        req;
  logic        ack;
  logic        busy;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic        de_req;
  logic        de_ack;
  logic [17:0] de_addr;
  logic [3:0]  de_nbyte;
  logic [31:0] de_data;

  modport master (
    output req, r0, r1, r2, r3, r4, r5, r6, r7, de_ack,
    input  ack, busy, de_req, de_addr, de_nbyte, de_data
  );

  modport slave (
    input  req, r0, r1, r2, r3, r4, r5, r6, r7, de_ack,
    output ack, busy, de_req, de_addr, de_nbyte, de_data
  );
endinterface

// File: rtl/drawing_fractal.sv
// Escape-time Mandelbrot/Julia renderer: one pixel at a time, one z iteration per cycle,
// each finished pixel written to the frame store through a req/ack handshake.
module drawing_fractal #(
  parameter int Q_LEN    = 46,
  parameter int FRAC_LEN = 40,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic               clk,
  input  logic               rst,
  drawing_fractal_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ITER, WRITE} state_t;

  localparam logic [19:0] X_LAST = 20'(SCREEN_W - 1);
  localparam logic [19:0] Y_LAST = 20'(SCREEN_H - 1);
  localparam logic [2*Q_LEN:0] FOUR = (2*Q_LEN+1)'(1) << (2*FRAC_LEN + 2);

  function automatic logic signed [Q_LEN-1:0] to_coord(input logic [15:0] r);
    return {r, {(Q_LEN-16){1'b0}}};
  endfunction

  function automatic logic signed [Q_LEN-1:0] to_step(input logic [15:0] r);
    return {6'b0, r, {(FRAC_LEN-16){1'b0}}};
  endfunction

  state_t                   state;
  logic                     ack, busy, de_req;
  logic [7:0]               pix;
  logic [19:0]              addr, x, y;
  logic [15:0]              max_iter, iter;
  logic                     julia, inset_zero;
  logic signed [Q_LEN-1:0]  start_r, step_x, step_y, jr, ji;
  logic signed [Q_LEN-1:0]  pr, pi, zr, zi, cr, ci;

  logic signed [2*Q_LEN-1:0] sq_r, sq_i, prod;
  logic [Q_LEN-1:0]          prod_t;
  logic [2*Q_LEN:0]          mag;
  logic signed [Q_LEN-1:0]   nzr, nzi;
  logic                      escape, done;
  logic signed [Q_LEN-1:0]   load_pr, load_pi, load_cr, load_ci, jc_r, jc_i;
  logic                      use_julia;
  logic                      unused_bits;

  // Escape test uses the full-width squares so |z|^2 can never wrap.
  always_comb begin
    sq_r   = zr * zr;
    sq_i   = zi * zi;
    prod   = zr * zi;
    prod_t = prod[Q_LEN+FRAC_LEN-1:FRAC_LEN];
    mag    = {1'b0, sq_r} + {1'b0, sq_i};
    escape = (mag >= FOUR);
    done   = escape || (iter >= max_iter);
    nzr    = sq_r[Q_LEN+FRAC_LEN-1:FRAC_LEN] - sq_i[Q_LEN+FRAC_LEN-1:FRAC_LEN] + cr;
    nzi    = {prod_t[Q_LEN-2:0], 1'b0} + ci;
  end

  // Start point of the next pixel: from the command registers in IDLE, else stepped.
  always_comb begin
    load_pr   = pr + step_x;
    load_pi   = pi;
    use_julia = julia;
    jc_r      = jr;
    jc_i      = ji;
    if (state == IDLE) begin
      load_pr   = to_coord(bus.r1);
      load_pi   = to_coord(bus.r2);
      use_julia = bus.r5[0];
      jc_r      = to_coord(bus.r6);
      jc_i      = to_coord(bus.r7);
    end else if (x == X_LAST) begin
      load_pr = start_r;
      load_pi = pi + step_y;
    end
    load_cr = use_julia ? jc_r : load_pr;
    load_ci = use_julia ? jc_i : load_pi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ack        <= 1'b0;
      busy       <= 1'b0;
      de_req     <= 1'b0;
      pix        <= '0;
      addr       <= '0;
      x          <= '0;
      y          <= '0;
      max_iter   <= '0;
      iter       <= '0;
      julia      <= 1'b0;
      inset_zero <= 1'b0;
      start_r    <= '0;
      step_x     <= '0;
      step_y     <= '0;
      jr         <= '0;
      ji         <= '0;
      pr         <= '0;
      pi         <= '0;
      zr         <= '0;
      zi         <= '0;
      cr         <= '0;
      ci         <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          if (bus.req) begin
            max_iter   <= bus.r0;
            start_r    <= to_coord(bus.r1);
            step_x     <= to_step(bus.r3);
            step_y     <= to_step(bus.r4);
            julia      <= bus.r5[0];
            inset_zero <= bus.r5[1];
            jr         <= to_coord(bus.r6);
            ji         <= to_coord(bus.r7);
            x          <= '0;
            y          <= '0;
            addr       <= '0;
            pr         <= load_pr;
            pi         <= load_pi;
            zr         <= load_pr;
            zi         <= load_pi;
            cr         <= load_cr;
            ci         <= load_ci;
            iter       <= 16'd1;
            ack        <= 1'b1;
            busy       <= 1'b1;
            state      <= ITER;
          end
        end
        ITER: begin
          ack <= 1'b0;
          if (done) begin
            pix    <= (inset_zero && !escape) ? 8'd0 : iter[7:0];
            de_req <= 1'b1;
            state  <= WRITE;
          end else begin
            zr   <= nzr;
            zi   <= nzi;
            iter <= iter + 16'd1;
          end
        end
        WRITE: begin
          if (bus.de_ack) begin
            de_req <= 1'b0;
            if (x == X_LAST && y == Y_LAST) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              if (x == X_LAST) begin
                x <= '0;
                y <= y + 20'd1;
              end else begin
                x <= x + 20'd1;
              end
              addr  <= addr + 20'd1;
              pr    <= load_pr;
              pi    <= load_pi;
              zr    <= load_pr;
              zi    <= load_pi;
              cr    <= load_cr;
              ci    <= load_ci;
              iter  <= 16'd1;
              state <= ITER;
            end
          end
        end
        default: begin
          ack    <= 1'b0;
          busy   <= 1'b0;
          de_req <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack      = ack;
  assign bus.busy     = busy;
  assign bus.de_req   = de_req;
  assign bus.de_addr  = addr[19:2];
  assign bus.de_nbyte = ~(4'b0001 << addr[1:0]);
  assign bus.de_data  = {4{pix}};

  assign unused_bits = ^{bus.r5[15:2], prod[2*Q_LEN-1:Q_LEN+FRAC_LEN], prod[FRAC_LEN-1:0], prod_t[Q_LEN-1]};

endmodule

// File: tb/tb_drawing_fractal.sv
// Directed bench for drawing_fractal on an 8x4 screen: reset, frame timing,
// escape/in-set colouring, Julia mode, write-handshake stall and mid-frame reset.
module tb_drawing_fractal;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  drawing_fractal_if bus();

  drawing_fractal #(.Q_LEN(46), .FRAC_LEN(40), .SCREEN_W(8), .SCREEN_H(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [17:0] wr_addr [64];
  logic [3:0]  wr_nbyte[64];
  logic [31:0] wr_data [64];
  int          wr_cyc  [64];
  int          nwr, last_wr, busy_low, seen;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7);
    bus.r0 = a0; bus.r1 = a1; bus.r2 = a2; bus.r3 = a3;
    bus.r4 = a4; bus.r5 = a5; bus.r6 = a6; bus.r7 = a7;
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
  endtask

  // Records every acknowledged write until busy drops or the budget expires.
  task automatic runFrame(input int budget);
    nwr = 0; last_wr = -1; busy_low = -1;
    for (int c = 0; c < budget; c++) begin
      if (bus.de_req && bus.de_ack) begin
        if (nwr < 64) begin
          wr_addr[nwr]  = bus.de_addr;
          wr_nbyte[nwr] = bus.de_nbyte;
          wr_data[nwr]  = bus.de_data;
          wr_cyc[nwr]   = c;
        end
        last_wr = c;
        nwr++;
      end
      if (!bus.busy) begin
        busy_low = c;
        break;
      end
      tick();
    end
  endtask

  initial begin
    bus.req = 1'b0; bus.de_ack = 1'b1;
    bus.r0 = '0; bus.r1 = '0; bus.r2 = '0; bus.r3 = '0;
    bus.r4 = '0; bus.r5 = '0; bus.r6 = '0; bus.r7 = '0;

    rst = 1'b1;
    repeat (3) tick();
    checkOutput("rst_ack",    32'(bus.ack),      32'd0);
    checkOutput("rst_busy",   32'(bus.busy),     32'd0);
    checkOutput("rst_de_req", 32'(bus.de_req),   32'd0);
    checkOutput("rst_addr",   32'(bus.de_addr),  32'd0);
    checkOutput("rst_nbyte",  32'(bus.de_nbyte), 32'hE);
    checkOutput("rst_data",   bus.de_data,       32'd0);

    bus.r0 = 16'd1;
    bus.req = 1'b1;
    tick();
    checkOutput("rst_prio_ack",  32'(bus.ack),  32'd0);
    checkOutput("rst_prio_busy", 32'(bus.busy), 32'd0);
    bus.req = 1'b0;
    rst = 1'b0;
    tick();

    applyStimulus(16'd1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("req_ack",  32'(bus.ack),  32'd1);
    checkOutput("req_busy", 32'(bus.busy), 32'd1);
    tick();
    checkOutput("ack_one_cycle", 32'(bus.ack),  32'd0);
    checkOutput("busy_held",     32'(bus.busy), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);

    $display("[TB] single-iteration frame");
    applyStimulus(16'd1, 0, 0, 0, 0, 0, 0, 0);
    runFrame(200);
    checkOutput("t2_writes",   32'(nwr),          32'd32);
    checkOutput("t2_addr0",    32'(wr_addr[0]),   32'd0);
    checkOutput("t2_nbyte0",   32'(wr_nbyte[0]),  32'hE);
    checkOutput("t2_data0",    wr_data[0],        32'h01010101);
    checkOutput("t2_addr5",    32'(wr_addr[5]),   32'd1);
    checkOutput("t2_nbyte5",   32'(wr_nbyte[5]),  32'hD);
    checkOutput("t2_addr31",   32'(wr_addr[31]),  32'd7);
    checkOutput("t2_nbyte31",  32'(wr_nbyte[31]), 32'h7);
    checkOutput("t2_busy_fall", 32'(busy_low - last_wr), 32'd1);

    $display("[TB] escape at 2.0");
    applyStimulus(16'd100, 16'h0800, 0, 0, 0, 0, 0, 0);
    runFrame(200);
    checkOutput("t3a_writes", 32'(nwr), 32'd32);
    for (int i = 0; i < 32; i++)
      checkOutput($sformatf("t3a_data%0d", i), wr_data[i], 32'h01010101);
    checkOutput("t3a_period", 32'(wr_cyc[1] - wr_cyc[0]), 32'd2);

    $display("[TB] in-set pixels at max iteration");
    applyStimulus(16'h0105, 0, 0, 0, 0, 0, 0, 0);
    runFrame(10000);
    checkOutput("t3b_writes", 32'(nwr),   32'd32);
    checkOutput("t3b_data0",  wr_data[0],  32'h05050505);
    checkOutput("t3b_data31", wr_data[31], 32'h05050505);
    checkOutput("t3b_period", 32'(wr_cyc[1] - wr_cyc[0]), 32'd262);

    applyStimulus(16'h0105, 0, 0, 0, 0, 16'd2, 0, 0);
    runFrame(10000);
    checkOutput("t3c_writes", 32'(nwr),   32'd32);
    checkOutput("t3c_data0",  wr_data[0],  32'h00000000);
    checkOutput("t3c_data31", wr_data[31], 32'h00000000);

    $display("[TB] julia mode");
    applyStimulus(16'd100, 16'h0600, 0, 0, 0, 16'd1, 0, 0);
    runFrame(300);
    checkOutput("t4a_writes", 32'(nwr),   32'd32);
    checkOutput("t4a_data0",  wr_data[0],  32'h02020202);
    checkOutput("t4a_data31", wr_data[31], 32'h02020202);
    checkOutput("t4a_period", 32'(wr_cyc[1] - wr_cyc[0]), 32'd3);

    applyStimulus(16'd100, 16'h0600, 0, 16'h8000, 0, 16'd1, 0, 0);
    runFrame(300);
    checkOutput("t4b_writes", 32'(nwr),  32'd32);
    checkOutput("t4b_data0",  wr_data[0], 32'h02020202);
    checkOutput("t4b_data1",  wr_data[1], 32'h01010101);
    checkOutput("t4b_data7",  wr_data[7], 32'h01010101);
    checkOutput("t4b_data8",  wr_data[8], 32'h02020202);

    $display("[TB] write handshake stall");
    bus.de_ack = 1'b0;
    applyStimulus(16'd1, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 20; c++) begin
      if (bus.de_req) break;
      tick();
    end
    checkOutput("t5_req_up", 32'(bus.de_req), 32'd1);
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    checkOutput("t5_no_ack", 32'(bus.ack), 32'd0);
    repeat (9) tick();
    checkOutput("t5_req_held", 32'(bus.de_req),   32'd1);
    checkOutput("t5_addr",     32'(bus.de_addr),  32'd0);
    checkOutput("t5_nbyte",    32'(bus.de_nbyte), 32'hE);
    checkOutput("t5_data",     bus.de_data,       32'h01010101);
    bus.de_ack = 1'b1;
    tick();
    checkOutput("t5_req_drop", 32'(bus.de_req), 32'd0);
    tick();
    checkOutput("t5_next_req",   32'(bus.de_req),   32'd1);
    checkOutput("t5_next_nbyte", 32'(bus.de_nbyte), 32'hD);
    rst = 1'b1; tick(); rst = 1'b0;

    $display("[TB] reset mid-frame");
    applyStimulus(16'd1, 0, 0, 0, 0, 0, 0, 0);
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      if (bus.de_req) begin
        if (seen == 13) break;
        seen++;
      end
      tick();
    end
    checkOutput("t6_px13_addr",  32'(bus.de_addr),  32'd3);
    checkOutput("t6_px13_nbyte", 32'(bus.de_nbyte), 32'hD);
    rst = 1'b1; tick(); rst = 1'b0;
    checkOutput("t6_req_off",  32'(bus.de_req), 32'd0);
    checkOutput("t6_busy_off", 32'(bus.busy),   32'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("t6_quiet", 32'(bus.de_req), 32'd0);
    end
    applyStimulus(16'd1, 0, 0, 0, 0, 0, 0, 0);
    runFrame(200);
    checkOutput("t6_writes", 32'(nwr),         32'd32);
    checkOutput("t6_addr0",  32'(wr_addr[0]),  32'd0);
    checkOutput("t6_nbyte0", 32'(wr_nbyte[0]), 32'hE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
